// File: rtl/booth_radix4_mul.sv
// Radix-4 (modified) Booth multiplier, iterative, two multiplier bits per cycle.
// Operands are extended by two bits so one datapath serves signed and unsigned
// products. The full product of the extended operands is formed in an
// {accumulator, multiplier} shift pair; the low 2*WIDTH bits are the result.
// WIDTH must be even and at least 4.
module booth_radix4_mul #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic               signed_mode,
  input  logic [WIDTH-1:0]   M,
  input  logic [WIDTH-1:0]   Q,
  output logic [2*WIDTH-1:0] P,
  output logic               busy,
  output logic               done
);

  // Extended operand width, accumulator width, step count, counter width.
  // The two extra accumulator bits keep +/-2M of the most negative extended
  // multiplicand representable.
  localparam int EW = WIDTH + 2;
  localparam int AW = EW + 2;
  localparam int N  = WIDTH / 2 + 1;
  localparam int CW = $clog2(N + 1);

  localparam logic [CW-1:0] N_CNT   = CW'(N);
  localparam logic [CW-1:0] ONE_CNT = CW'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state_reg, state_next;

  logic [EW-1:0] m_reg;     // extended multiplicand, frozen for the whole operation
  logic [EW-1:0] q_reg;     // multiplier; product low bits shift in from the top
  logic          qm1_reg;   // implicit bit q[2i-1] of the current triplet
  logic [AW-1:0] acc_reg;   // partial-product accumulator
  logic [CW-1:0] cnt_reg;   // remaining Booth steps

  logic [EW-1:0]      m_ext;
  logic [EW-1:0]      q_ext;
  logic [AW-1:0]      m_aw;
  logic [AW-1:0]      m2_aw;
  logic [2:0]         triplet;
  logic [AW-1:0]      pp;
  logic [AW-1:0]      sum;
  logic [AW-1:0]      acc_shift;
  logic [EW-1:0]      q_shift;
  logic [2*WIDTH-1:0] product;
  logic               start;
  logic               last_step;

  // The mode only decides how the operands are extended, so it is folded into
  // the captured operands and needs no register of its own.
  assign m_ext = signed_mode ? {{2{M[WIDTH-1]}}, M} : {2'b00, M};
  assign q_ext = signed_mode ? {{2{Q[WIDTH-1]}}, Q} : {2'b00, Q};

  // A new operation may start from IDLE or straight out of DONE.
  assign start     = load && (state_reg != CALC);
  assign last_step = (state_reg == CALC) && (cnt_reg == ONE_CNT);

  // Booth recoding, add, then arithmetic shift of the {acc, q} pair by two.
  always_comb begin
    m_aw    = {{2{m_reg[EW-1]}}, m_reg};
    m2_aw   = {m_aw[AW-2:0], 1'b0};
    triplet = {q_reg[1:0], qm1_reg};
    pp      = '0;
    case (triplet)
      3'b001, 3'b010: pp = m_aw;
      3'b011:         pp = m2_aw;
      3'b100:         pp = '0 - m2_aw;
      3'b101, 3'b110: pp = '0 - m_aw;
      default:        pp = '0;
    endcase
    sum       = acc_reg + pp;
    acc_shift = {{2{sum[AW-1]}}, sum[AW-1:2]};
    q_shift   = {sum[1:0], q_reg[EW-1:2]};
    product   = {acc_shift[WIDTH-3:0], q_shift};
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state decode and status outputs.
  always_comb begin
    state_next = state_reg;
    busy       = 1'b0;
    done       = 1'b0;
    case (state_reg)
      IDLE: begin
        if (load) state_next = CALC;
      end
      CALC: begin
        busy = 1'b1;
        if (cnt_reg == ONE_CNT) state_next = DONE;
      end
      DONE: begin
        done       = 1'b1;
        state_next = load ? CALC : IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Operand capture on start, one Booth step per CALC cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      m_reg   <= '0;
      q_reg   <= '0;
      qm1_reg <= 1'b0;
      acc_reg <= '0;
      cnt_reg <= '0;
    end else if (start) begin
      m_reg   <= m_ext;
      q_reg   <= q_ext;
      qm1_reg <= 1'b0;
      acc_reg <= '0;
      cnt_reg <= N_CNT;
    end else if (state_reg == CALC) begin
      acc_reg <= acc_shift;
      q_reg   <= q_shift;
      qm1_reg <= q_reg[1];
      cnt_reg <= cnt_reg - ONE_CNT;
    end
  end

  // Product register: updated only on the edge that completes the last step.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      P <= '0;
    end else if (last_step) begin
      P <= product;
    end
  end

endmodule

// File: tb/tb_booth_radix4_mul.sv
// Self-checking bench for booth_radix4_mul at WIDTH = 8, 16 and 32:
// directed vector table, multi-cycle corner sequences, and random vectors
// compared with a plain-arithmetic product model.
module tb_booth_radix4_mul;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic        ld8, sm8, busy8, done8;
  logic [7:0]  m8, q8;
  logic [15:0] p8;
  logic        ld16, sm16, busy16, done16;
  logic [15:0] m16, q16;
  logic [31:0] p16;
  logic        ld32, sm32, busy32, done32;
  logic [31:0] m32, q32;
  logic [63:0] p32;

  booth_radix4_mul #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(reset), .load(ld8), .signed_mode(sm8),
    .M(m8), .Q(q8), .P(p8), .busy(busy8), .done(done8));
  booth_radix4_mul #(.WIDTH(16)) dut16 (
    .clk(clk), .reset(reset), .load(ld16), .signed_mode(sm16),
    .M(m16), .Q(q16), .P(p16), .busy(busy16), .done(done16));
  booth_radix4_mul #(.WIDTH(32)) dut32 (
    .clk(clk), .reset(reset), .load(ld32), .signed_mode(sm32),
    .M(m32), .Q(q32), .P(p32), .busy(busy32), .done(done32));

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    int          w;
    bit          s;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] exp;
    string       name;
  } vec_t;

  vec_t tbl[13];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input int w, input bit ld, input bit s,
                       input logic [63:0] a, input logic [63:0] b);
    case (w)
      8:       begin ld8  = ld; sm8  = s; m8  = a[7:0];  q8  = b[7:0];  end
      16:      begin ld16 = ld; sm16 = s; m16 = a[15:0]; q16 = b[15:0]; end
      default: begin ld32 = ld; sm32 = s; m32 = a[31:0]; q32 = b[31:0]; end
    endcase
  endtask

  function automatic logic [63:0] get_p(input int w);
    case (w)
      8:       return 64'(p8);
      16:      return 64'(p16);
      default: return p32;
    endcase
  endfunction

  function automatic logic get_done(input int w);
    case (w)
      8:       return done8;
      16:      return done16;
      default: return done32;
    endcase
  endfunction

  function automatic logic get_busy(input int w);
    case (w)
      8:       return busy8;
      16:      return busy16;
      default: return busy32;
    endcase
  endfunction

  // Reference: extend each operand to 64 bits per mode, multiply, keep 2*w bits.
  function automatic logic [63:0] ext(input int w, input bit s, input logic [63:0] x);
    logic [63:0] m;
    logic [63:0] v;
    m = (64'd1 << w) - 64'd1;
    v = x & m;
    if (s && v[w-1]) v = v | ~m;
    return v;
  endfunction

  function automatic logic [63:0] ref_mul(input int w, input bit s,
                                          input logic [63:0] a, input logic [63:0] b);
    logic [63:0] m2;
    m2 = (w == 32) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << (2 * w)) - 64'd1);
    return (ext(w, s, a) * ext(w, s, b)) & m2;
  endfunction

  function automatic logic [63:0] rnd_op(input int w);
    logic [63:0] m;
    int sel;
    m   = (64'd1 << w) - 64'd1;
    sel = $urandom_range(0, 7);
    case (sel)
      0:       return 64'd0;
      1:       return m;
      2:       return 64'd1 << (w - 1);
      3:       return (64'd1 << (w - 1)) - 64'd1;
      default: return {$urandom, $urandom} & m;
    endcase
  endfunction

  // Waits (bounded) for done; k = edges counted, -1 if it never came.
  task automatic wait_done(input int w, output int k, output logic [63:0] p, output int busy_low);
    k = -1;
    p = '0;
    busy_low = 0;
    for (int c = 1; c <= 64; c++) begin
      @(negedge clk);
      if (get_done(w)) begin
        k = c;
        p = get_p(w);
        break;
      end
      if (!get_busy(w)) busy_low++;
    end
  endtask

  task automatic do_op(input int w, input bit s, input logic [63:0] a,
                       input logic [63:0] b, input logic [63:0] exp, input string name);
    int k;
    int bl;
    logic [63:0] p;
    @(negedge clk);
    drive(w, 1'b1, s, a, b);
    @(negedge clk);
    drive(w, 1'b0, s, a, b);
    wait_done(w, k, p, bl);
    check({name, " latency"}, 64'(k), 64'(w / 2 + 1));
    check({name, " P"}, p, exp);
    check({name, " busy in CALC"}, 64'(bl), 64'd0);
    $display("op %s w=%0d s=%0d M=0x%0h Q=0x%0h P=0x%0h lat=%0d", name, w, s, a, b, p, k);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    int bl;
    int dcount;
    logic [63:0] p;
    logic [63:0] prev;

    tbl[0]  = '{32, 1'b1, 64'hFFFF_FFFB, 64'hFFFF_FFFA, 64'd30, "s_neg5_neg6"};
    tbl[1]  = '{32, 1'b1, 64'd10, 64'hFFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFE2, "s_10_neg3"};
    tbl[2]  = '{32, 1'b1, 64'h7FFF_FFFF, 64'h8000_0000, 64'hC000_0000_8000_0000, "s_max_min"};
    tbl[3]  = '{32, 1'b1, 64'h8000_0000, 64'h8000_0000, 64'h4000_0000_0000_0000, "s_min_min"};
    tbl[4]  = '{32, 1'b0, 64'hFFFF_FFFF, 64'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, "u_ff_ff"};
    tbl[5]  = '{32, 1'b1, 64'hFFFF_FFFF, 64'hFFFF_FFFF, 64'd1, "s_m1_m1"};
    tbl[6]  = '{32, 1'b0, 64'd0, 64'h1234_5678, 64'd0, "u_zero"};
    tbl[7]  = '{32, 1'b0, 64'h8000_0000, 64'd2, 64'h1_0000_0000, "u_msb_x2"};
    tbl[8]  = '{8,  1'b1, 64'h80, 64'h80, 64'h4000, "w8_s_min_min"};
    tbl[9]  = '{8,  1'b0, 64'hFF, 64'hFF, 64'hFE01, "w8_u_ff_ff"};
    tbl[10] = '{16, 1'b0, 64'hFFFF, 64'hFFFF, 64'hFFFE_0001, "w16_u_ff_ff"};
    tbl[11] = '{16, 1'b1, 64'h8000, 64'h7FFF, 64'hC000_8000, "w16_s_min_max"};
    tbl[12] = '{8,  1'b1, 64'h7F, 64'h80, 64'hC080, "w8_s_max_min"};

    // Reset state.
    reset = 1'b1;
    drive(8, 1'b0, 1'b0, 64'd0, 64'd0);
    drive(16, 1'b0, 1'b0, 64'd0, 64'd0);
    drive(32, 1'b0, 1'b0, 64'd0, 64'd0);
    repeat (2) @(negedge clk);
    check("reset P32", p32, 64'd0);
    check("reset busy32", 64'(busy32), 64'd0);
    check("reset done32", 64'(done32), 64'd0);
    check("reset P8", 64'(p8), 64'd0);
    check("reset busy16", 64'(busy16), 64'd0);
    reset = 1'b0;

    // Directed vector table.
    for (int i = 0; i < 13; i++)
      do_op(tbl[i].w, tbl[i].s, tbl[i].a, tbl[i].b, tbl[i].exp, tbl[i].name);

    // Load during CALC is ignored; operands changing mid-CALC have no effect.
    prev = p32;
    @(negedge clk);
    drive(32, 1'b1, 1'b0, 64'd100, 64'd200);
    @(negedge clk);
    drive(32, 1'b0, 1'b0, 64'd100, 64'd200);
    for (int c = 1; c <= 4; c++) @(negedge clk);
    drive(32, 1'b1, 1'b1, 64'd3, 64'd3);
    @(negedge clk);
    check("ignored_load busy", 64'(busy32), 64'd1);
    check("ignored_load P hold", p32, prev);
    drive(32, 1'b0, 1'b1, 64'd3, 64'd3);
    wait_done(32, k, p, bl);
    check("ignored_load latency", 64'(k + 5), 64'd17);
    check("ignored_load P", p, 64'd20000);
    dcount = 0;
    for (int c = 0; c < 25; c++) begin
      @(negedge clk);
      if (done32) dcount++;
    end
    check("ignored_load extra done", 64'(dcount), 64'd0);
    $display("op ignored_load P=0x%0h lat=%0d", p, k + 5);

    // Reset in the middle of CALC aborts without a done pulse.
    @(negedge clk);
    drive(32, 1'b1, 1'b0, 64'd1000, 64'd1000);
    @(negedge clk);
    drive(32, 1'b0, 1'b0, 64'd1000, 64'd1000);
    for (int c = 1; c <= 7; c++) @(negedge clk);
    reset = 1'b1;
    #1;
    check("midreset P", p32, 64'd0);
    check("midreset busy", 64'(busy32), 64'd0);
    check("midreset done", 64'(done32), 64'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    dcount = 0;
    for (int c = 0; c < 25; c++) begin
      @(negedge clk);
      if (done32 || busy32) dcount++;
    end
    check("midreset no done", 64'(dcount), 64'd0);
    $display("op midreset abort P=0x%0h", p32);

    // Load on the first edge after reset release is accepted.
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    drive(32, 1'b1, 1'b1, 64'd7, 64'hFFFF_FFFC);
    @(negedge clk);
    drive(32, 1'b0, 1'b1, 64'd7, 64'hFFFF_FFFC);
    wait_done(32, k, p, bl);
    check("post_reset latency", 64'(k), 64'd17);
    check("post_reset P", p, 64'hFFFF_FFFF_FFFF_FFE4);
    $display("op post_reset 7*-4 P=0x%0h lat=%0d", p, k);

    // Back-to-back: load held through DONE starts the next operation.
    @(negedge clk);
    drive(32, 1'b1, 1'b0, 64'd6, 64'd7);
    @(negedge clk);
    drive(32, 1'b0, 1'b0, 64'd6, 64'd7);
    wait_done(32, k, p, bl);
    check("b2b first P", p, 64'd42);
    drive(32, 1'b1, 1'b0, 64'd15, 64'd15);
    @(negedge clk);
    check("b2b restart busy", 64'(busy32), 64'd1);
    check("b2b done single", 64'(done32), 64'd0);
    drive(32, 1'b0, 1'b0, 64'd15, 64'd15);
    wait_done(32, k, p, bl);
    check("b2b latency", 64'(k), 64'd17);
    check("b2b P", p, 64'd225);
    @(negedge clk);
    check("b2b done drops", 64'(done32), 64'd0);
    $display("op b2b 15*15 P=0x%0h lat=%0d", p, k);

    // Random vectors against the reference model, all widths in parallel.
    fork
      begin
        for (int i = 0; i < 2000; i++) begin
          logic [63:0] a, b;
          bit s;
          s = (i >= 1000);
          a = rnd_op(8);
          b = rnd_op(8);
          do_op(8, s, a, b, ref_mul(8, s, a, b), "rnd8");
        end
      end
      begin
        for (int i = 0; i < 2000; i++) begin
          logic [63:0] a, b;
          bit s;
          s = (i >= 1000);
          a = rnd_op(16);
          b = rnd_op(16);
          do_op(16, s, a, b, ref_mul(16, s, a, b), "rnd16");
        end
      end
      begin
        for (int i = 0; i < 400; i++) begin
          logic [63:0] a, b;
          bit s;
          s = (i >= 200);
          a = rnd_op(32);
          b = rnd_op(32);
          do_op(32, s, a, b, ref_mul(32, s, a, b), "rnd32");
        end
      end
    join

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
